// File: rtl/clk_div_ctrl.sv
// Run-time reconfiguration sequencer for a clock divider: gates the divided clock,
// swaps the division factor, waits for the divider to settle, then ungates.
module clk_div_ctrl #(
  parameter int DIV_WIDTH   = 4,
  parameter int RESET_DIV   = 1,
  parameter int GATE_CYCLES = 2
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 req_valid_i,
  input  logic [DIV_WIDTH-1:0] req_div_i,
  output logic                 req_ready_o,
  output logic [DIV_WIDTH-1:0] div_o,
  output logic                 clk_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);

  // Request port: a transfer happens on a rising clk_i edge with req_valid_i & req_ready_o;
  // req_ready_o is high only in IDLE, and the request inputs are ignored outside IDLE.

  localparam int CNT_W = DIV_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    UPDATE = 2'd2,
    SETTLE = 2'd3
  } state_t;

  state_t               state;
  logic [DIV_WIDTH-1:0] pending;
  logic [CNT_W-1:0]     cnt;
  logic [DIV_WIDTH-1:0] eff;
  logic [CNT_W-1:0]     settle_load;
  logic [CNT_W-1:0]     gate_load;

  // A divider programmed with 0 behaves as divide-by-1, so settle on at least one period.
  assign eff         = (pending == '0) ? DIV_WIDTH'(1) : pending;
  assign settle_load = {eff, 1'b0} - CNT_W'(1);
  assign gate_load   = CNT_W'(GATE_CYCLES - 1);

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state    <= IDLE;
      div_o    <= DIV_WIDTH'(RESET_DIV);
      pending  <= '0;
      cnt      <= '0;
      clk_en_o <= 1'b1;
      done_o   <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            if (req_div_i == div_o) begin
              done_o <= 1'b1;
            end else begin
              pending  <= req_div_i;
              cnt      <= gate_load;
              clk_en_o <= 1'b0;
              state    <= GATE;
            end
          end
        end
        GATE: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           state <= UPDATE;
        end
        UPDATE: begin
          div_o <= pending;
          cnt   <= settle_load;
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state    <= IDLE;
            clk_en_o <= 1'b1;
            done_o   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state == IDLE);
  assign busy_o      = (state != IDLE);
  assign state_o     = state;

endmodule
